cpu_control: RTL and testbench

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_control.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_control.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control.sv
// cpu_control -- instruction register and control FSM for a simple datapath.
//
// Holds a 16-bit instruction register (IR) and steps each instruction through
// WAIT -> DECODE -> {GET_A} -> {GET_B} -> {ALU} -> {WRITE_REG | WRITE_IMM} -> WAIT.
// All datapath controls are Moore outputs. They are computed from the next
// state and next IR and then registered, so they stay glitch-free and change
// only on clk.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   s               start executing the instruction held in IR (sampled in WAIT)
//   load, in[15:0]  load the instruction register (honoured only while w=1)
//   w               idle flag, 1 only in WAIT
//   readnum/writenum register-file read/write selects
//   vsel            writeback source: 00 = C, 10 = sximm8
//   loada/loadb/loadc/loads/write  datapath strobes
//   asel/bsel       source-operand selects (bsel is always 0)
//   shift, ALUop    shifter / ALU controls
//   sximm8, sximm5  IR[7:0] / IR[4:0] sign-extended, combinational from IR
//   state_dbg       current FSM state, for debug visibility
//   retired[15:0]   retired-instruction count; present only when the macro
//                   CPU_CONTROL_RETIRE_CNT_EN is defined
//
// Handshake: s is a level start request. It is accepted on any rising edge
// where the FSM is in WAIT. Holding s high starts the next instruction on the
// edge right after the FSM returns to WAIT.

module cpu_control (
   input  logic        clk,
   input  logic        reset,
   input  logic        s,
   input  logic        load,
   input  logic [15:0] in,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic [1:0]  vsel,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        write,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5,
`ifdef CPU_CONTROL_RETIRE_CNT_EN
   output logic [15:0] retired,
`endif
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_GET_A     = 3'd2,
      S_GET_B     = 3'd3,
      S_ALU       = 3'd4,
      S_WRITE_REG = 3'd5,
      S_WRITE_IMM = 3'd6
   } state_t;

   typedef struct packed {
      logic       w;
      logic [2:0] readnum;
      logic [2:0] writenum;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       write;
      logic       asel;
      logic       bsel;
      logic [1:0] shift;
      logic [1:0] aluop;
   } ctrl_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] ir;
   logic [15:0] ir_nxt;
   ctrl_t       ctrl;

   logic [2:0]  opcode;
   logic [1:0]  op;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];

   // Control word for a given state and instruction.
   function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] word);
      ctrl_t c;
      logic  mov_reg;
      logic  cmp;
      c       = '0;
      mov_reg = (word[15:13] == 3'b110) && (word[12:11] == 2'b00);
      cmp     = (word[15:13] == 3'b101) && (word[12:11] == 2'b01);
      case (st)
         S_WAIT:  c.w = 1'b1;
         S_GET_A: begin
            c.readnum = word[10:8];
            c.loada   = 1'b1;
         end
         S_GET_B: begin
            c.readnum = word[2:0];
            c.loadb   = 1'b1;
         end
         S_ALU: begin
            c.loadc = 1'b1;
            c.shift = word[4:3];
            // MOV reg passes B through the ALU as an ADD with A forced to 0.
            c.aluop = mov_reg ? 2'b00 : word[12:11];
            c.asel  = mov_reg;
            c.loads = cmp;
         end
         S_WRITE_REG: begin
            c.writenum = word[7:5];
            c.vsel     = 2'b00;
            c.write    = 1'b1;
         end
         S_WRITE_IMM: begin
            c.writenum = word[10:8];
            c.vsel     = 2'b10;
            c.write    = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // IR only accepts a new word while idle.
   always_comb begin
      ir_nxt = ir;
      if (load && (state == S_WAIT)) ir_nxt = in;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:   if (s) state_nxt = S_DECODE;
         S_DECODE: begin
            state_nxt = S_WAIT;  // unknown encodings fall straight back to idle
            if (opcode == 3'b110 && op == 2'b10)
               state_nxt = S_WRITE_IMM;
            else if ((opcode == 3'b110 && op == 2'b00) ||
                     (opcode == 3'b101 && op == 2'b11))
               state_nxt = S_GET_B;
            else if (opcode == 3'b101)
               state_nxt = S_GET_A;
         end
         S_GET_A:  state_nxt = S_GET_B;
         S_GET_B:  state_nxt = S_ALU;
         // CMP only updates status, so it retires directly from ALU.
         S_ALU:    state_nxt = (opcode == 3'b101 && op == 2'b01) ? S_WAIT : S_WRITE_REG;
         S_WRITE_REG, S_WRITE_IMM: state_nxt = S_WAIT;
         default:  state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_WAIT;
         ir    <= '0;
         ctrl  <= ctrl_for(S_WAIT, 16'h0000);
      end else begin
         state <= state_nxt;
         ir    <= ir_nxt;
         ctrl  <= ctrl_for(state_nxt, ir_nxt);
      end
   end

   assign w         = ctrl.w;
   assign readnum   = ctrl.readnum;
   assign writenum  = ctrl.writenum;
   assign vsel      = ctrl.vsel;
   assign loada     = ctrl.loada;
   assign loadb     = ctrl.loadb;
   assign loadc     = ctrl.loadc;
   assign loads     = ctrl.loads;
   assign write     = ctrl.write;
   assign asel      = ctrl.asel;
   assign bsel      = ctrl.bsel;
   assign shift     = ctrl.shift;
   assign ALUop     = ctrl.aluop;
   assign state_dbg = state;

   assign sximm8 = {{8{ir[7]}}, ir[7:0]};
   assign sximm5 = {{11{ir[4]}}, ir[4:0]};

`ifdef CPU_CONTROL_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
   logic        retire_evt;

   // Every legal instruction returns to WAIT from exactly one of these states.
   assign retire_evt = (state == S_WRITE_REG) || (state == S_WRITE_IMM) ||
                       ((state == S_ALU) && (opcode == 3'b101) && (op == 2'b01));

   always_ff @(posedge clk) begin
      if (reset)           retire_cnt <= '0;
      else if (retire_evt) retire_cnt <= retire_cnt + 16'd1;
   end

   assign retired = retire_cnt;
`endif

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control -- randomized scoreboard bench for cpu_control.
// Driver tasks issue loads and starts and push the expected per-cycle output
// vectors into exp_q. A monitor pops one entry per cycle, 1 time unit after
// each rising edge, and compares it with the DUT outputs.

module tb_cpu_control;

   logic        clk;
   logic        reset;
   logic        s;
   logic        load;
   logic [15:0] in;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic [1:0]  vsel;
   logic        loada;
   logic        loadb;
   logic        loadc;
   logic        loads;
   logic        write;
   logic        asel;
   logic        bsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic [15:0] sximm8;
   logic [15:0] sximm5;
   logic [2:0]  state_dbg;
`ifdef CPU_CONTROL_RETIRE_CNT_EN
   logic [15:0] retired;
   int          m_retired;
`endif

   cpu_control dut (
      .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
      .w(w), .readnum(readnum), .writenum(writenum), .vsel(vsel),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .write(write), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
      .sximm8(sximm8), .sximm5(sximm5),
`ifdef CPU_CONTROL_RETIRE_CNT_EN
      .retired(retired),
`endif
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard ----------------
   logic [51:0] exp_q[$];
   logic [15:0] m_ir;
   int          n_checks;
   int          n_fail;

   localparam logic [6:0] LA = 7'b1000000;
   localparam logic [6:0] LB = 7'b0100000;
   localparam logic [6:0] LC = 7'b0010000;
   localparam logic [6:0] LS = 7'b0001000;
   localparam logic [6:0] WR = 7'b0000100;
   localparam logic [6:0] AS = 7'b0000010;
   localparam logic [6:0] NONE = 7'b0000000;

   // Expected output vector: {w, readnum, writenum, vsel,
   // loada, loadb, loadc, loads, write, asel, bsel, shift, ALUop, sximm8, sximm5}.
   function automatic logic [51:0] vec(input logic w_v, input logic [2:0] rnum,
                                       input logic [2:0] wnum, input logic [1:0] vs,
                                       input logic [6:0] strobes, input logic [1:0] sh,
                                       input logic [1:0] alu, input logic [15:0] ir_v);
      logic signed [15:0] x8;
      logic signed [15:0] x5;
      x8 = 16'(signed'(ir_v[7:0]));
      x5 = 16'(signed'(ir_v[4:0]));
      return {w_v, rnum, wnum, vs, strobes, sh, alu, x8, x5};
   endfunction

   function automatic logic [51:0] idle_vec(input logic [15:0] ir_v);
      return vec(1'b1, 3'd0, 3'd0, 2'b00, NONE, 2'b00, 2'b00, ir_v);
   endfunction

   // Reference model: the full cycle-by-cycle response to one start of ir_v.
   task automatic push_instr(input logic [15:0] ir_v);
      logic [2:0] opc;
      logic [1:0] op;
      logic [2:0] rn;
      logic [2:0] rd;
      logic [2:0] rm;
      logic [1:0] sh;
      bit         is_mov;
      bit         is_cmp;
      opc = ir_v[15:13];
      op  = ir_v[12:11];
      rn  = ir_v[10:8];
      rd  = ir_v[7:5];
      sh  = ir_v[4:3];
      rm  = ir_v[2:0];
      exp_q.push_back(vec(1'b0, 3'd0, 3'd0, 2'b00, NONE, 2'b00, 2'b00, ir_v));
      if (opc == 3'b110 && op == 2'b10) begin                       // MOV imm
         exp_q.push_back(vec(1'b0, 3'd0, rn, 2'b10, WR, 2'b00, 2'b00, ir_v));
`ifdef CPU_CONTROL_RETIRE_CNT_EN
         m_retired++;
`endif
      end else if ((opc == 3'b110 && op == 2'b00) ||
                   (opc == 3'b101 && op == 2'b11)) begin            // MOV reg, MVN
         is_mov = (opc == 3'b110);
         exp_q.push_back(vec(1'b0, rm, 3'd0, 2'b00, LB, 2'b00, 2'b00, ir_v));
         exp_q.push_back(vec(1'b0, 3'd0, 3'd0, 2'b00, is_mov ? (LC | AS) : LC,
                             sh, is_mov ? 2'b00 : op, ir_v));
         exp_q.push_back(vec(1'b0, 3'd0, rd, 2'b00, WR, 2'b00, 2'b00, ir_v));
`ifdef CPU_CONTROL_RETIRE_CNT_EN
         m_retired++;
`endif
      end else if (opc == 3'b101) begin                             // ADD, CMP, AND
         is_cmp = (op == 2'b01);
         exp_q.push_back(vec(1'b0, rn, 3'd0, 2'b00, LA, 2'b00, 2'b00, ir_v));
         exp_q.push_back(vec(1'b0, rm, 3'd0, 2'b00, LB, 2'b00, 2'b00, ir_v));
         exp_q.push_back(vec(1'b0, 3'd0, 3'd0, 2'b00, is_cmp ? (LC | LS) : LC,
                             sh, op, ir_v));
         if (!is_cmp)
            exp_q.push_back(vec(1'b0, 3'd0, rd, 2'b00, WR, 2'b00, 2'b00, ir_v));
`ifdef CPU_CONTROL_RETIRE_CNT_EN
         m_retired++;
`endif
      end
      exp_q.push_back(idle_vec(ir_v));
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [51:0] act;
      logic [51:0] exp;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            act = {w, readnum, writenum, vsel, loada, loadb, loadc, loads, write,
                   asel, bsel, shift, ALUop, sximm8, sximm5};
            n_checks++;
            if (act !== exp) begin
               n_fail++;
               $display("FAIL out_vec t=%0t ir=%h state=%0d actual=%h expected=%h",
                        $time, m_ir, state_dbg, act, exp);
            end
         end
      end
   end

   // ---------------- driver tasks (entered and left just after a negedge) ----------------
   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset(input logic s_v, input logic load_v, input logic [15:0] in_v);
      reset = 1'b1;
      s     = s_v;
      load  = load_v;
      in    = in_v;
      m_ir  = 16'h0000;
      exp_q.delete();
      exp_q.push_back(idle_vec(16'h0000));
`ifdef CPU_CONTROL_RETIRE_CNT_EN
      m_retired = 0;
`endif
      @(negedge clk);
      reset = 1'b0;
      s     = 1'b0;
      load  = 1'b0;
      in    = 16'h0000;
      drain();
   endtask

   task automatic load_ir(input logic [15:0] word);
      load = 1'b1;
      in   = word;
      m_ir = word;
      exp_q.push_back(idle_vec(word));
      @(negedge clk);
      load = 1'b0;
      in   = 16'h0000;
      drain();
   endtask

   task automatic start_only();
      s = 1'b1;
      push_instr(m_ir);
      @(negedge clk);
      s = 1'b0;
   endtask

   task automatic run(input logic [15:0] word);
      load_ir(word);
      start_only();
      drain();
   endtask

   function automatic logic [15:0] rand_instr();
      logic [31:0] r;
      logic [2:0]  opc;
      logic [1:0]  op;
      r = $urandom();
      case ($urandom_range(0, 6))
         0: begin opc = 3'b110; op = 2'b10; end
         1: begin opc = 3'b110; op = 2'b00; end
         2: begin opc = 3'b101; op = 2'b11; end
         3: begin opc = 3'b101; op = 2'b00; end
         4: begin opc = 3'b101; op = 2'b01; end
         5: begin opc = 3'b101; op = 2'b10; end
         default: begin opc = r[31:29]; op = r[28:27]; end
      endcase
      return {opc, op, r[10:0]};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] dir_tab[6];
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      s        = 1'b0;
      load     = 1'b0;
      in       = 16'h0000;
      m_ir     = 16'h0000;
`ifdef CPU_CONTROL_RETIRE_CNT_EN
      m_retired = 0;
`endif
      exp_q.push_back(idle_vec(16'h0000));
      @(negedge clk);
      reset = 1'b0;
      drain();

      // MOV imm, ADD, CMP, illegal, MVN, AND
      dir_tab = '{16'hD0FB, 16'hA148, 16'hA900, 16'hE000, 16'hB8E7, 16'hB25D};
      foreach (dir_tab[i]) run(dir_tab[i]);

      // MOV reg with a load attempt while busy: IR must keep 0xC064.
      load_ir(16'hC064);
      start_only();
      load = 1'b1;
      in   = 16'hFFFF;
      @(negedge clk);
      @(negedge clk);
      load = 1'b0;
      in   = 16'h0000;
      drain();
      start_only();  // rerun without reloading
      drain();

      // s held high: the second start follows the edge after returning to WAIT.
      load_ir(16'hD57F);
      s = 1'b1;
      push_instr(m_ir);
      push_instr(m_ir);
      repeat (4) @(negedge clk);
      s = 1'b0;
      drain();

      // Reset in the middle of an ADD (state GET_B).
      load_ir(16'hA7A9);
      start_only();
      repeat (2) @(negedge clk);
      do_reset(1'b0, 1'b0, 16'h0000);

      // Reset dominates a simultaneous start and load.
      load_ir(16'hA148);
      do_reset(1'b1, 1'b1, 16'hD0FB);

      // Randomized instructions.
      for (int k = 0; k < 40; k++) run(rand_instr());

`ifdef CPU_CONTROL_RETIRE_CNT_EN
      do_reset(1'b0, 1'b0, 16'h0000);
      run(16'hD0FB);
      run(16'hA900);
      run(16'hE000);
      run(16'hA148);
      n_checks++;
      if (retired !== 16'(m_retired)) begin
         n_fail++;
         $display("FAIL retired_count actual=%h expected=%h", retired, 16'(m_retired));
      end
      force dut.retire_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.retire_cnt;
      run(16'hD001);
      n_checks++;
      if (retired !== 16'h0000) begin
         n_fail++;
         $display("FAIL retired_wrap actual=%h expected=0000", retired);
      end
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
